// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch queue.
// Queue entries pair a fetch PC with its instruction word.
package fetch_pkg;

    localparam int FQ_XLEN  = 32;
    localparam int FQ_DEPTH = 8;
    localparam int FQ_PTR_W = $clog2(FQ_DEPTH);

    localparam logic [FQ_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] instr;
    } fq_entry_t;

    localparam fq_entry_t FQ_EMPTY = '{pc: '0, instr: NOP_INSTR};

    // A fill count of 3 is clamped to the two words memory can return.
    function automatic logic [1:0] fill_words(input logic [1:0] cnt);
        return (cnt == 2'd3) ? 2'd2 : cnt;
    endfunction

endpackage

// File: rtl/fetch_issue_queue_storage.sv
// Circular entry buffer for the fetch queue: two write and two read ports.
// Pure storage; pointers and occupancy live in the parent.
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = FQ_PTR_W
) (
    input  logic             clk,
    input  logic             we0,
    input  logic             we1,
    input  logic [PTR_W-1:0] waddr0,
    input  logic [PTR_W-1:0] waddr1,
    input  fq_entry_t        wdata0,
    input  fq_entry_t        wdata1,
    input  logic [PTR_W-1:0] raddr0,
    input  logic [PTR_W-1:0] raddr1,
    output fq_entry_t        rdata0,
    output fq_entry_t        rdata1
);

    fq_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_issue_queue.sv
// Dual-issue fetch buffer: queues fetched words and issues up to two
// per cycle, in program order, into the two decode slots.
module fetch_issue_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = FQ_DEPTH,
    parameter int              XLEN     = FQ_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [XLEN-1:0]            FetchPC,
    input  logic                       FillValid,
    input  logic [1:0]                 FillCount,
    input  logic [XLEN-1:0]            FillInstr0,
    input  logic [XLEN-1:0]            FillInstr1,
    output logic                       FillReady,
    input  logic                       Redirect,
    input  logic [XLEN-1:0]            RedirectPC,
    input  logic                       StallFetch1,
    input  logic                       StallFetch2,
    input  logic                       StallDecode1,
    input  logic                       StallDecode2,
    input  logic                       FlushDecode1,
    input  logic                       FlushDecode2,
    output logic [XLEN-1:0]            InstrD1,
    output logic [XLEN-1:0]            InstrD2,
    output logic [XLEN-1:0]            PCD1,
    output logic [XLEN-1:0]            PCD2,
    output logic                       ValidD1,
    output logic                       ValidD2,
    output logic [$clog2(DEPTH+1)-1:0] QCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic [XLEN-1:0]  pc_q;
    fq_entry_t        s1_q, s2_q, s1_d, s2_d;
    logic             v1_q, v2_q, v1_d, v2_d;

    logic      accept;
    logic [1:0] n_push, n_pop;
    logic      load1, load2;
    fq_entry_t rd0, rd1, wd0, wd1;
    logic      unused_bits;

    assign unused_bits = &{1'b0, RedirectPC[1:0]};

    assign FillReady = ((DEPTH_C - count_q) >= CW'(2))
                     && !StallFetch1 && !StallFetch2 && !Redirect;
    assign accept = FillValid && FillReady;
    assign n_push = accept ? fill_words(FillCount) : 2'd0;

    assign wd0 = '{pc: pc_q, instr: FillInstr0};
    assign wd1 = '{pc: pc_q + XLEN'(4), instr: FillInstr1};

    fq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_store (
        .clk    (clk),
        .we0    (n_push != 2'd0),
        .we1    (n_push == 2'd2),
        .waddr0 (tail_q),
        .waddr1 (tail_q + PTR_W'(1)),
        .wdata0 (wd0),
        .wdata1 (wd1),
        .raddr0 (head_q),
        .raddr1 (head_q + PTR_W'(1)),
        .rdata0 (rd0),
        .rdata1 (rd1)
    );

    assign load1 = !Redirect && !FlushDecode1 && !StallDecode1;
    assign load2 = !Redirect && !FlushDecode2 && !StallDecode2;

    // Slot 1 is always served first; slot 2 gets head only when slot 1 holds.
    always_comb begin
        n_pop = 2'd0;
        v1_d  = v1_q;
        s1_d  = s1_q;
        v2_d  = v2_q;
        s2_d  = s2_q;
        if (Redirect || FlushDecode1) begin
            v1_d = 1'b0;
            s1_d = FQ_EMPTY;
        end
        if (Redirect || FlushDecode2) begin
            v2_d = 1'b0;
            s2_d = FQ_EMPTY;
        end
        if (load1) begin
            v1_d = (count_q != '0);
            s1_d = v1_d ? rd0 : FQ_EMPTY;
            n_pop = {1'b0, v1_d};
            if (load2) begin
                v2_d  = (count_q >= CW'(2));
                s2_d  = v2_d ? rd1 : FQ_EMPTY;
                n_pop = n_pop + {1'b0, v2_d};
            end
        end else if (load2) begin
            v2_d  = (count_q != '0);
            s2_d  = v2_d ? rd0 : FQ_EMPTY;
            n_pop = {1'b0, v2_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_PC;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            s1_q    <= FQ_EMPTY;
            s2_q    <= FQ_EMPTY;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            if (Redirect) begin
                head_q  <= tail_q;
                count_q <= '0;
                pc_q    <= {RedirectPC[XLEN-1:2], 2'b00};
            end else begin
                head_q  <= head_q + PTR_W'(n_pop);
                tail_q  <= tail_q + PTR_W'(n_push);
                count_q <= count_q + CW'(n_push) - CW'(n_pop);
                pc_q    <= pc_q + (XLEN'(n_push) << 2);
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= DEPTH_C);
            assert (CW'(n_pop) <= count_q);
        end
    end
`endif

    assign FetchPC = pc_q;
    assign InstrD1 = s1_q.instr;
    assign InstrD2 = s2_q.instr;
    assign PCD1    = s1_q.pc;
    assign PCD2    = s2_q.pc;
    assign ValidD1 = v1_q;
    assign ValidD2 = v2_q;
    assign QCount  = count_q;

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Directed bench for fetch_issue_queue: fill, stall, wrap, redirect
// and asynchronous reset sequences with hand-computed expectations.
module tb_fetch_issue_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        fill_valid;
    logic [1:0]  fill_count;
    logic [31:0] fill_instr0, fill_instr1;
    logic        fill_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_f1, stall_f2, stall_d1, stall_d2;
    logic        flush_d1, flush_d2;
    logic [31:0] instr_d1, instr_d2, pc_d1, pc_d2;
    logic        valid_d1, valid_d2;
    logic [3:0]  qcount;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    assign fill_instr0 = mem_word(fetch_pc);
    assign fill_instr1 = mem_word(fetch_pc + 32'd4);

    fetch_issue_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .FetchPC      (fetch_pc),
        .FillValid    (fill_valid),
        .FillCount    (fill_count),
        .FillInstr0   (fill_instr0),
        .FillInstr1   (fill_instr1),
        .FillReady    (fill_ready),
        .Redirect     (redirect),
        .RedirectPC   (redirect_pc),
        .StallFetch1  (stall_f1),
        .StallFetch2  (stall_f2),
        .StallDecode1 (stall_d1),
        .StallDecode2 (stall_d2),
        .FlushDecode1 (flush_d1),
        .FlushDecode2 (flush_d2),
        .InstrD1      (instr_d1),
        .InstrD2      (instr_d2),
        .PCD1         (pc_d1),
        .PCD2         (pc_d2),
        .ValidD1      (valid_d1),
        .ValidD2      (valid_d2),
        .QCount       (qcount)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; fill_valid = 0; fill_count = 0;
        redirect = 0; redirect_pc = 0;
        stall_f1 = 0; stall_f2 = 0; stall_d1 = 0; stall_d2 = 0;
        flush_d1 = 0; flush_d2 = 0;
        #12;
        chk("rst_pc", fetch_pc, 32'h0);
        chk("rst_q", {28'd0, qcount}, 32'd0);
        chk("rst_v1", {31'd0, valid_d1}, 32'd0);
        chk("rst_v2", {31'd0, valid_d2}, 32'd0);
        chk("rst_i1", instr_d1, NOP);
        chk("rst_pcd2", pc_d2, 32'h0);

        // steady dual fill, no stalls
        rst_n = 1; fill_valid = 1; fill_count = 2;
        #1 chk("t1_ready", {31'd0, fill_ready}, 32'd1);
        step();
        chk("t1_pc_e1", fetch_pc, 32'd8);
        chk("t1_q_e1", {28'd0, qcount}, 32'd2);
        chk("t1_v1_e1", {31'd0, valid_d1}, 32'd0);
        step();
        chk("t1_pcd1", pc_d1, 32'd0);
        chk("t1_pcd2", pc_d2, 32'd4);
        chk("t1_i1", instr_d1, 32'hC000_0000);
        chk("t1_i2", instr_d2, 32'hC000_0004);
        chk("t1_v2", {31'd0, valid_d2}, 32'd1);
        chk("t1_pc_e2", fetch_pc, 32'd16);
        step();
        chk("t1_pcd1_b", pc_d1, 32'd8);
        chk("t1_pcd2_b", pc_d2, 32'd12);
        chk("t1_pc_e3", fetch_pc, 32'd24);
        chk("t1_q_e3", {28'd0, qcount}, 32'd2);

        // decode stalled: queue fills to 7, fill rejected
        stall_d1 = 1; stall_d2 = 1;
        step(); step();
        chk("t2_q6", {28'd0, qcount}, 32'd6);
        chk("t2_pc40", fetch_pc, 32'd40);
        fill_count = 1;
        step();
        chk("t2_q7", {28'd0, qcount}, 32'd7);
        chk("t2_ready0", {31'd0, fill_ready}, 32'd0);
        step();
        chk("t2_q_hold", {28'd0, qcount}, 32'd7);
        chk("t2_pc_hold", fetch_pc, 32'd44);
        chk("t2_pcd1_hold", pc_d1, 32'd8);
        chk("t2_pcd2_hold", pc_d2, 32'd12);

        // slot 2 stalled only
        fill_valid = 0; stall_d1 = 0;
        step();
        chk("t3_pcd1", pc_d1, 32'h10);
        chk("t3_pcd2", pc_d2, 32'd12);
        chk("t3_q6", {28'd0, qcount}, 32'd6);
        stall_d2 = 0;
        step(); step(); step();
        chk("t3_pcd1_end", pc_d1, 32'd36);
        chk("t3_pcd2_end", pc_d2, 32'd40);
        chk("t3_q0", {28'd0, qcount}, 32'd0);

        // mixed fill counts, single entry at head=7, tail wrap
        stall_d1 = 1; stall_d2 = 1; fill_valid = 1; fill_count = 1;
        step();
        fill_count = 2;
        step();
        fill_count = 1;
        step(); step();
        chk("t5_q5", {28'd0, qcount}, 32'd5);
        chk("t5_pc64", fetch_pc, 32'd64);
        fill_valid = 0; stall_d1 = 0; stall_d2 = 0;
        step();
        chk("t5_pcd1_a", pc_d1, 32'd44);
        chk("t5_pcd2_a", pc_d2, 32'd48);
        step();
        chk("t5_q1", {28'd0, qcount}, 32'd1);
        step();
        chk("t5_pcd1_h7", pc_d1, 32'd60);
        chk("t5_v1_h7", {31'd0, valid_d1}, 32'd1);
        chk("t5_v2_h7", {31'd0, valid_d2}, 32'd0);
        chk("t5_i2_nop", instr_d2, NOP);
        chk("t5_pcd2_0", pc_d2, 32'd0);
        chk("t5_q0", {28'd0, qcount}, 32'd0);
        fill_valid = 1; fill_count = 2;
        step();
        chk("t5_pc72", fetch_pc, 32'd72);
        chk("t5_v1_empty", {31'd0, valid_d1}, 32'd0);
        fill_valid = 0;
        step();
        chk("t5_wrap_pcd1", pc_d1, 32'd64);
        chk("t5_wrap_pcd2", pc_d2, 32'd68);
        chk("t5_wrap_i2", instr_d2, 32'hC000_0044);

        // redirect with queue at 5, fill and flush pending
        stall_d1 = 1; stall_d2 = 1; fill_valid = 1; fill_count = 2;
        step(); step();
        fill_count = 1;
        step();
        chk("t4_q5", {28'd0, qcount}, 32'd5);
        redirect = 1; redirect_pc = 32'h203; fill_count = 2; flush_d1 = 1;
        #1 chk("t4_ready0", {31'd0, fill_ready}, 32'd0);
        step();
        chk("t4_q0", {28'd0, qcount}, 32'd0);
        chk("t4_v1", {31'd0, valid_d1}, 32'd0);
        chk("t4_v2", {31'd0, valid_d2}, 32'd0);
        chk("t4_pc", fetch_pc, 32'h200);
        chk("t4_i1", instr_d1, NOP);
        redirect = 0; flush_d1 = 0; stall_d1 = 0; stall_d2 = 0;
        step();
        chk("t4_pc_b", fetch_pc, 32'h208);
        chk("t4_q2", {28'd0, qcount}, 32'd2);
        step();
        chk("t4_pcd1", pc_d1, 32'h200);
        chk("t4_pcd2", pc_d2, 32'h204);

        // fill count 3 acts as 2, fill count 0 pushes nothing
        fill_count = 3;
        step();
        chk("fc3_pc", fetch_pc, 32'h218);
        chk("fc3_q", {28'd0, qcount}, 32'd2);
        fill_count = 0;
        step();
        chk("fc0_pc", fetch_pc, 32'h218);
        chk("fc0_pcd2", pc_d2, 32'h214);
        chk("fc0_q", {28'd0, qcount}, 32'd0);

        // asynchronous reset mid-stream
        stall_d1 = 1; stall_d2 = 1; fill_count = 2;
        step(); step(); step();
        chk("t6_q6", {28'd0, qcount}, 32'd6);
        chk("t6_pc", fetch_pc, 32'h230);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_pc", fetch_pc, 32'h0);
        chk("t6_rst_q", {28'd0, qcount}, 32'd0);
        chk("t6_rst_v1", {31'd0, valid_d1}, 32'd0);
        chk("t6_rst_i2", instr_d2, NOP);
        chk("t6_rst_pcd1", pc_d1, 32'h0);
        fill_valid = 0; stall_d1 = 0; stall_d2 = 0;
        #10 rst_n = 1;
        step();
        chk("t6_post_pc", fetch_pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_issue_queue.md
Name: fetch_issue_queue

Overview:
Dual-issue instruction fetch buffer. It sits between instruction memory and the two decode-stage registers. It holds fetched words in a circular queue and issues up to two instructions per cycle, in program order, into lane-1/lane-2 decode slots. It acts on the stall, flush and redirect controls produced by the hazard unit and the execute-stage branch logic; it owns the decode pipeline registers and the fetch PC.

Parameters:
DEPTH, 8, queue entries; power of two, at least 4
XLEN, 32, instruction and PC width
RESET_PC, 32'h0000_0000, FetchPC value after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
FetchPC  out  XLEN  address presented to instruction memory this cycle
FillValid  in  1  instruction memory returns words for FetchPC this cycle
FillCount  in  2  number of valid words returned (1 or 2)
FillInstr0  in  XLEN  word at FetchPC
FillInstr1  in  XLEN  word at FetchPC+4
FillReady  out  1  queue will accept a fill this cycle
Redirect  in  1  taken branch or jump resolved in execute
RedirectPC  in  XLEN  redirect target
StallFetch1, StallFetch2  in  1  fetch stall from hazard unit
StallDecode1, StallDecode2  in  1  hold decode slot N
FlushDecode1, FlushDecode2  in  1  kill decode slot N
InstrD1, InstrD2  out  XLEN  decode slot instruction
PCD1, PCD2  out  XLEN  decode slot PC
ValidD1, ValidD2  out  1  decode slot holds a live instruction
QCount  out  $clog2(DEPTH+1)  current queue occupancy

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - head, tail and QCount = 0.
  - ValidD1/2 = 0; InstrD1/2 = NOP (32'h0000_0013); PCD1/2 = 0.
  - FetchPC = RESET_PC.
- FillReady is combinational: (DEPTH − QCount ≥ 2) && !StallFetch1 && !StallFetch2 && !Redirect.
- Fill acceptance: a fill is accepted when FillValid && FillReady.
  - Push FillCount entries {pc, instr}: FillInstr0 at FetchPC; FillInstr1 at FetchPC+4 when FillCount ≥ 2.
  - FillCount = 0: no push, FetchPC holds.
  - FillCount = 3: treated as 2.
  - FetchPC <= FetchPC + 4·pushed, wrapping modulo 2^XLEN.
- Fetch stall: StallFetch1 or StallFetch2 holds FetchPC and rejects fills.
- Slot N next state, in priority order:
  1. Redirect: invalid.
  2. FlushDecodeN: invalid; the instruction is discarded.
  3. StallDecodeN: hold all slot fields.
  4. Otherwise: load from the queue.
- Invalid slots present InstrDN = NOP and PCDN = 0.
- Dequeue order:
  - Loads use only entries present at the start of the cycle; there is no fill-to-slot bypass. Minimum latency is fill at edge k, slot valid after edge k+1.
  - Both slots loading: slot 1 takes head, slot 2 takes head+1.
  - One slot loading: it takes head.
  - Fewer entries than loading slots: slot 1 is served first; an unserved slot becomes invalid.
  - Ordering guarantee: when both slots load in the same cycle, PCD1 < PCD2 (program order).
- Occupancy: QCount_next = QCount + pushed − popped. Head and tail wrap modulo DEPTH. Simultaneous push and pop at full or empty is legal: the full check uses the start-of-cycle count and pop does not free space for the same-cycle fill.
- Redirect at the edge:
  - head = tail, QCount = 0, both slots invalid.
  - FetchPC <= RedirectPC; any fill that cycle is dropped.
  - Redirect overrides all stall and flush inputs.
- RedirectPC[1:0] is ignored: the target is forced to 4-byte alignment.
- Error checks (simulation-only assertions): QCount never exceeds DEPTH; no pop from an empty queue.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR constant.
  - fq_entry_t struct {pc, instr}.
  - FQ_PTR_W derived from DEPTH.
- Sub-module fq_storage: circular buffer of fq_entry_t with two write ports and two read ports (reads at head and head+1). It holds no control logic; pointers and count stay in fetch_issue_queue.

Test Plan:
1. Reset then continuous FillValid/FillCount=2, no stalls -> FetchPC steps 0,8,16,…; slots show PC 0/4, then 8/12; first valid slots two edges after first fill; QCount settles at 0 or 2.
2. Assert StallDecode1=StallDecode2=1 while filling -> slots hold; QCount climbs to 8; FillReady drops at QCount=7; FetchPC freezes at 32.
3. Queue at QCount=3 with StallDecode2 only -> slot 1 takes head (PC 0x10); slot 2 holds; next cycle QCount=2 if no fill.
4. Redirect=1, RedirectPC=0x200 while QCount=5, FillValid=1, FlushDecode1=1 -> next cycle QCount=0, ValidD1/2=0, FetchPC=0x200, fill dropped.
5. FillCount=1 alternating with 2, and a single entry left at the queue-wrap boundary (head=7) -> slot 1 valid with PC from entry 7, slot 2 invalid/NOP; tail wraps to 0 correctly.
6. rst_n pulsed low mid-stream with QCount=6 -> all outputs return to reset values immediately, without waiting for a clock edge; FetchPC=RESET_PC.
